hazard_control: RTL and testbench



---
 rtl/hazard_control_if.sv | 56 +++++
 rtl/hazard_control.sv | 127 ++++++++++++
 tb/tb_hazard_control.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_if.sv
// ============================================================================
// Module      : hazard_control_if
// Description : Hazard-control signal bundle between pipeline datapath and
//               the stall/flush controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_control_if;
  logic [2:0]  id_src1;
  logic [2:0]  id_src2;
  logic        id_src1_used;
  logic        id_src2_used;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_load_regfile;
  logic [2:0]  ex_dest;
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic        mem_indirect;
  logic        mem_br_taken;
  logic        load_pc;
  logic        load_if_id;
  logic        load_id_ex;
  logic        load_ex_mem;
  logic        load_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        indirect_phase;
  logic [15:0] stall_cycles;

  modport master (
    output id_src1, id_src2, id_src1_used, id_src2_used,
    output ex_valid, ex_mem_read, ex_load_regfile, ex_dest,
    output imem_read, imem_resp, dmem_req, dmem_resp,
    output mem_indirect, mem_br_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  flush_if_id, flush_id_ex, flush_ex_mem,
    input  indirect_phase, stall_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_src1_used, id_src2_used,
    input  ex_valid, ex_mem_read, ex_load_regfile, ex_dest,
    input  imem_read, imem_resp, dmem_req, dmem_resp,
    input  mem_indirect, mem_br_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output flush_if_id, flush_id_ex, flush_ex_mem,
    output indirect_phase, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_control.sv
// ============================================================================
// Module      : hazard_control
// Description : LC-3b five-stage pipeline stall/flush controller with
//               indirect-access sequencing and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_control (
  input  wire logic       clk,
  input  wire logic       rst,
  hazard_control_if.slave hc
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_IND2 = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_stall_cycles;

  logic w_mem_busy;
  logic w_load_use;
  logic w_load_pc;
  logic w_load_if_id;
  logic w_load_id_ex;
  logic w_load_ex_mem;
  logic w_load_mem_wb;
  logic w_flush_if_id;
  logic w_flush_id_ex;
  logic w_flush_ex_mem;
  logic w_indirect_phase;

  // The first indirect access is never a completion: it only fetches the pointer.
  assign w_mem_busy = (hc.imem_read & ~hc.imem_resp)
                    | (hc.dmem_req  & ~hc.dmem_resp)
                    | ((r_state == S_RUN) & hc.mem_indirect & hc.dmem_req);

  assign w_load_use = hc.ex_valid & hc.ex_mem_read & hc.ex_load_regfile
                    & ((hc.id_src1_used & (hc.id_src1 == hc.ex_dest))
                     | (hc.id_src2_used & (hc.id_src2 == hc.ex_dest)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_pc        = 1'b1;
    w_load_if_id     = 1'b1;
    w_load_id_ex     = 1'b1;
    w_load_ex_mem    = 1'b1;
    w_load_mem_wb    = 1'b1;
    w_flush_if_id    = 1'b0;
    w_flush_id_ex    = 1'b0;
    w_flush_ex_mem   = 1'b0;
    w_indirect_phase = (r_state == S_IND2);

    case (r_state)
      S_RUN: begin
        if (hc.mem_indirect && hc.dmem_req && hc.dmem_resp) begin
          w_state_next = S_IND2;
        end
      end
      S_IND2: begin
        if (hc.dmem_req && hc.dmem_resp) begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_RUN;
    endcase

    if (rst) begin
      w_load_pc        = 1'b0;
      w_load_if_id     = 1'b0;
      w_load_id_ex     = 1'b0;
      w_load_ex_mem    = 1'b0;
      w_load_mem_wb    = 1'b0;
      w_flush_if_id    = 1'b1;
      w_flush_id_ex    = 1'b1;
      w_flush_ex_mem   = 1'b1;
      w_indirect_phase = 1'b0;
    end else if (w_mem_busy) begin
      w_load_pc     = 1'b0;
      w_load_if_id  = 1'b0;
      w_load_id_ex  = 1'b0;
      w_load_ex_mem = 1'b0;
      w_load_mem_wb = 1'b0;
    end else if (hc.mem_br_taken) begin
      w_flush_if_id  = 1'b1;
      w_flush_id_ex  = 1'b1;
      w_flush_ex_mem = 1'b1;
    end else if (w_load_use) begin
      w_load_pc     = 1'b0;
      w_load_if_id  = 1'b0;
      w_flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 16'h0000;
    end else if (!w_load_pc && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'h0001;
    end
  end

  assign hc.load_pc        = w_load_pc;
  assign hc.load_if_id     = w_load_if_id;
  assign hc.load_id_ex     = w_load_id_ex;
  assign hc.load_ex_mem    = w_load_ex_mem;
  assign hc.load_mem_wb    = w_load_mem_wb;
  assign hc.flush_if_id    = w_flush_if_id;
  assign hc.flush_id_ex    = w_flush_id_ex;
  assign hc.flush_ex_mem   = w_flush_ex_mem;
  assign hc.indirect_phase = w_indirect_phase;
  assign hc.stall_cycles   = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
// ============================================================================
// Module      : tb_hazard_control
// Description : Self-checking bench for hazard_control: directed scenarios
//               plus random traffic against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_control;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_control_if bus ();

  hazard_control dut (
    .clk (clk),
    .rst (rst),
    .hc  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: "second indirect access pending" flag and an unbounded count.
  bit m_ind2;
  int m_cnt;

  typedef struct packed {
    logic [4:0] ld;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [2:0] fl;   // if_id, id_ex, ex_mem
    logic       iph;
  } exp_t;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   busy, hit;
    busy = (bus.imem_read && !bus.imem_resp) || (bus.dmem_req && !bus.dmem_resp)
        || (!m_ind2 && bus.mem_indirect && bus.dmem_req);
    hit  = bus.ex_valid && bus.ex_mem_read && bus.ex_load_regfile &&
           ((bus.id_src1_used && bus.id_src1 == bus.ex_dest) ||
            (bus.id_src2_used && bus.id_src2 == bus.ex_dest));
    if (rst)                   e = '{ld: 5'b00000, fl: 3'b111, iph: 1'b0};
    else if (busy)             e = '{ld: 5'b00000, fl: 3'b000, iph: m_ind2};
    else if (bus.mem_br_taken) e = '{ld: 5'b11111, fl: 3'b111, iph: m_ind2};
    else if (hit)              e = '{ld: 5'b00111, fl: 3'b010, iph: m_ind2};
    else                       e = '{ld: 5'b11111, fl: 3'b000, iph: m_ind2};
    return e;
  endfunction

  task automatic step(input bit do_chk);
    exp_t e;
    #1;
    e = model_out();
    if (do_chk) begin
      chk("load_pc",        16'(bus.load_pc),        16'(e.ld[4]));
      chk("load_if_id",     16'(bus.load_if_id),     16'(e.ld[3]));
      chk("load_id_ex",     16'(bus.load_id_ex),     16'(e.ld[2]));
      chk("load_ex_mem",    16'(bus.load_ex_mem),    16'(e.ld[1]));
      chk("load_mem_wb",    16'(bus.load_mem_wb),    16'(e.ld[0]));
      chk("flush_if_id",    16'(bus.flush_if_id),    16'(e.fl[2]));
      chk("flush_id_ex",    16'(bus.flush_id_ex),    16'(e.fl[1]));
      chk("flush_ex_mem",   16'(bus.flush_ex_mem),   16'(e.fl[0]));
      chk("indirect_phase", 16'(bus.indirect_phase), 16'(e.iph));
      chk("stall_cycles",   bus.stall_cycles,        16'((m_cnt > 65535) ? 65535 : m_cnt));
    end
    @(posedge clk);
    if (rst) begin
      m_ind2 = 1'b0;
      m_cnt  = 0;
    end else begin
      if (!e.ld[4]) m_cnt++;
      if (bus.dmem_req && bus.dmem_resp) begin
        if (m_ind2) m_ind2 = 1'b0;
        else if (bus.mem_indirect) m_ind2 = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_src1 = 3'd0;  bus.id_src2 = 3'd0;
    bus.id_src1_used = 1'b0;  bus.id_src2_used = 1'b0;
    bus.ex_valid = 1'b0;  bus.ex_mem_read = 1'b0;
    bus.ex_load_regfile = 1'b0;  bus.ex_dest = 3'd0;
    bus.imem_read = 1'b1;  bus.imem_resp = 1'b1;
    bus.dmem_req = 1'b0;  bus.dmem_resp = 1'b0;
    bus.mem_indirect = 1'b0;  bus.mem_br_taken = 1'b0;
  endtask

  task automatic set_ldr_r3_hazard();
    bus.ex_valid = 1'b1;  bus.ex_mem_read = 1'b1;
    bus.ex_load_regfile = 1'b1;  bus.ex_dest = 3'd3;
    bus.id_src2 = 3'd3;  bus.id_src2_used = 1'b1;
  endtask

  initial begin
    m_ind2 = 1'b0;
    m_cnt  = 0;
    idle();
    // Reset forces outputs even with hazards present on the inputs
    rst = 1'b1;
    bus.dmem_req = 1'b1;  bus.mem_indirect = 1'b1;  bus.mem_br_taken = 1'b1;
    step(1);
    step(1);
    chk("rst_stall_zero", bus.stall_cycles, 16'h0000);
    rst = 1'b0;
    idle();
    step(1);

    // Load-use: one bubble then normal flow
    set_ldr_r3_hazard();
    step(1);
    chk("lu_stall_cnt", bus.stall_cycles, 16'd1);
    bus.ex_valid = 1'b0;
    step(1);
    chk("lu_release_pc", 16'(bus.load_pc), 16'd1);

    // No false stall: unused source, and non-load producer
    idle();
    bus.ex_valid = 1'b1;  bus.ex_mem_read = 1'b1;  bus.ex_load_regfile = 1'b1;
    bus.ex_dest = 3'd3;  bus.id_src1 = 3'd3;  bus.id_src1_used = 1'b0;
    step(1);
    idle();
    bus.ex_valid = 1'b1;  bus.ex_mem_read = 1'b0;  bus.ex_load_regfile = 1'b1;
    bus.ex_dest = 3'd3;  bus.id_src2 = 3'd3;  bus.id_src2_used = 1'b1;
    step(1);
    chk("nofalse_cnt", bus.stall_cycles, 16'd1);

    // dmem wait of three cycles
    idle();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) step(1);
    bus.dmem_resp = 1'b1;
    #1 chk("dmem_resp_load", 16'(bus.load_mem_wb), 16'd1);
    step(1);
    chk("dmem_wait_cnt", bus.stall_cycles, 16'd4);

    // LDI: two waits, first resp, two waits, second resp
    idle();
    bus.mem_indirect = 1'b1;  bus.dmem_req = 1'b1;
    for (int i = 0; i < 2; i++) step(1);
    bus.dmem_resp = 1'b1;
    step(1);
    chk("ldi_in_ind2", 16'(bus.indirect_phase), 16'd1);
    bus.dmem_resp = 1'b0;
    for (int i = 0; i < 2; i++) step(1);
    bus.dmem_resp = 1'b1;
    #1 chk("ldi_advance", 16'(bus.load_pc), 16'd1);
    step(1);
    chk("ldi_back_run", 16'(bus.indirect_phase), 16'd0);
    chk("ldi_stall_cnt", bus.stall_cycles, 16'd9);

    // Taken branch overriding a load-use hazard
    idle();
    set_ldr_r3_hazard();
    bus.mem_br_taken = 1'b1;
    #1 chk("br_flush_ex_mem", 16'(bus.flush_ex_mem), 16'd1);
    step(1);

    // Reset while in IND2
    idle();
    bus.mem_indirect = 1'b1;  bus.dmem_req = 1'b1;  bus.dmem_resp = 1'b1;
    step(1);
    bus.dmem_resp = 1'b0;
    chk("pre_rst_ind2", 16'(bus.indirect_phase), 16'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    idle();
    chk("rst_ind2_phase", 16'(bus.indirect_phase), 16'd0);
    chk("rst_ind2_cnt", bus.stall_cycles, 16'd0);
    step(1);

    // Random traffic, narrow register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      bus.id_src1 = 3'($urandom_range(0, 3));
      bus.id_src2 = 3'($urandom_range(0, 3));
      bus.id_src1_used = 1'($urandom);
      bus.id_src2_used = 1'($urandom);
      bus.ex_valid = 1'($urandom);
      bus.ex_mem_read = 1'($urandom);
      bus.ex_load_regfile = 1'($urandom);
      bus.ex_dest = 3'($urandom_range(0, 3));
      bus.imem_read = 1'($urandom);
      bus.imem_resp = ($urandom_range(0, 3) != 0);
      bus.dmem_req = 1'($urandom);
      bus.dmem_resp = 1'($urandom);
      bus.mem_indirect = ($urandom_range(0, 3) == 0);
      bus.mem_br_taken = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(1);
    end
    rst = 1'b0;

    // Saturation
    idle();
    bus.imem_resp = 1'b0;
    for (int i = 0; i < 70000; i++) step(0);
    step(1);
    chk("stall_saturated", bus.stall_cycles, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
